sr_cmd_gen: RTL and testbench
=============================

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 8, SHALL set the consecutive-cycle count a synchronized request must hold a new level before it is accepted (legal range 1..255).
REQ-002 Parameter RST_WINS, default 0, SHALL set collision policy: 0 = neither command issued, 1 = R issued.
REQ-003 clk  input  1  the single clock; all flops SHALL update on its rising edge.
REQ-004 rst  input  1  the reset, synchronous and active-high.
REQ-005 set_req  input  1  asynchronous, possibly bouncing set request; a rising level requests one set command.
REQ-006 clr_req  input  1  asynchronous, possibly bouncing clear request; a rising level requests one reset command.
REQ-007 S  output  1  registered one-cycle set command to the downstream SR flip-flop's S input.
REQ-008 R  output  1  registered one-cycle reset command to the downstream SR flip-flop's R input.
REQ-009 conflict  output  1  registered one-cycle flag marking a set/clear collision.

Function
REQ-010 Each request SHALL pass through a two-flop synchronizer; sync flops reset to 0.
REQ-011 Per channel, a stable level register and a counter SHALL exist.
- Counter increments each cycle the synchronized level differs from the stable level.
- Counter clears to 0 on any cycle the levels match.
REQ-012 On the DEB_CYCLES-th consecutive mismatch edge, the stable level SHALL take the synchronized value and the counter SHALL clear.
REQ-013 A 0->1 transition of a stable level SHALL raise that channel's command event for exactly one cycle; 1->0 transitions produce nothing.
REQ-014 Latency: with set_req first sampled 1 at edge k and held, S SHALL be 1 for exactly one cycle starting at edge k+2+DEB_CYCLES; same for clr_req/R.
REQ-015 Set event alone SHALL drive S=1, R=0; clear event alone SHALL drive S=0, R=1; no event SHALL drive S=0, R=0 (hold).
REQ-016 Set and clear events in the same cycle:
- RST_WINS=0: S=0, R=0.
- RST_WINS=1: S=0, R=1.
- In both cases conflict=1 for that one cycle.
REQ-017 S and R SHALL never both be 1 in any cycle, under any parameter, input or reset sequence.
REQ-018 Bounce shorter than DEB_CYCLES cycles SHALL produce no command; a held request SHALL produce exactly one command regardless of hold length.
REQ-019 Events one or more cycles apart SHALL each produce their own command with no conflict.

Reset
REQ-020 While rst=1 at an edge: S=0, R=0, conflict=0, sync flops=0, stable levels=0, counters=0.
REQ-021 Reset asserted mid-debounce or during a command cycle SHALL discard the pending event; outputs are 0 at the next edge.
REQ-022 A request held 1 through reset release SHALL be treated as a fresh rising level and issue one command per REQ-014, counted from the first post-reset edge.

Configuration
REQ-023 Macro SR_CMD_GEN_DEBOUNCE_EN:
- Defined: counters and debounce behaviour per REQ-011/012 are compiled in.
- Undefined: counters are absent; stable level = synchronized level each cycle; latency becomes edge k+2; DEB_CYCLES is ignored.
- All other requirements hold in both builds.

Verification
REQ-024 Macro defined, DEB_CYCLES=8: set_req 0->1 at edge 10, held 50 cycles -> S=1 only in the cycle starting at edge 20; R=0 and conflict=0 throughout.
REQ-025 clr_req toggling every 3 cycles for 30 cycles, then held 1 -> no R during toggling; exactly one R pulse, 10 edges after the final rise is first sampled.
REQ-026 set_req and clr_req rise on the same edge:
- RST_WINS=0 -> S=0, R=0, conflict=1 for one cycle.
- RST_WINS=1 -> R=1, S=0, conflict=1 for one cycle.
REQ-027 set_req rises 2 edges before clr_req -> S pulse, then R pulse 2 cycles later, conflict stays 0.
REQ-028 rst=1 for 2 cycles starting 4 cycles after set_req rises, set_req held -> no S during or right after reset; one S at post-reset edge +10.
REQ-029 Macro undefined: set_req rises at edge 5 -> S=1 in the cycle starting at edge 7; a 1-cycle glitch also yields one S pulse.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns two asynchronous, possibly bouncing request lines into
// clean one-cycle S / R commands for a downstream SR flip-flop.
// Each request is synchronized (two flops), optionally debounced, and
// edge-detected. Simultaneous set/clear events are resolved by RST_WINS,
// and are flagged on 'conflict'.
// Build option: define SR_CMD_GEN_DEBOUNCE_EN to compile in the per-channel
// debounce counters. Without it, the synchronized level is used directly
// and DEB_CYCLES has no effect.
module sr_cmd_gen #(
    parameter int unsigned DEB_CYCLES = 8,
    parameter bit          RST_WINS   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic S,
    output logic R,
    output logic conflict
);

    // Reject out-of-range debounce lengths when the design is elaborated.
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_deb_range_check
        $error("sr_cmd_gen: DEB_CYCLES must be in 1..255");
    end

    // Channel index 0 = set request, 1 = clear request.
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] lvl;
    logic [1:0] lvl_prev_q, lvl_prev_d;
    logic [1:0] ev;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       conflict_q, conflict_d;

    // Two-flop synchronizer inputs for both request channels.
    always_comb begin
        sync1_d = {clr_req, set_req};
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef SR_CMD_GEN_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [1:0]      stable_q, stable_d;
    logic [1:0][7:0] cnt_q, cnt_d;

    // Debounce: accept a new level only after DEB_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Stable-level and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign lvl = stable_q;
`else
    // Without debouncing the synchronized level is taken as stable as-is.
    assign lvl = sync2_q;
`endif

    // Rising-edge detection and collision resolution for the command outputs.
    always_comb begin
        lvl_prev_d = lvl;
        ev         = lvl & ~lvl_prev_q;
        s_d        = ev[0] & ~ev[1];
        r_d        = ev[1] & (~ev[0] | RST_WINS);
        conflict_d = ev[0] & ev[1];
    end

    // Edge-detector history and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_prev_q <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            lvl_prev_q <= lvl_prev_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: two instances (DEB_CYCLES=8/RST_WINS=0 and
// DEB_CYCLES=3/RST_WINS=1) share the same directed and random request
// traffic; every cycle their outputs are compared with a window-based
// reference model of synchronize / debounce / edge / collision behaviour.
module tb_sr_cmd_gen;

    localparam int MAXE = 8192;
`ifdef SR_CMD_GEN_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic set_req;
    logic clr_req;
    logic s0, r0, c0;
    logic s1, r1, c1;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;

    // Stimulus history (value sampled at each rising edge) and model state.
    bit xs [MAXE];
    bit xc [MAXE];
    bit rr [MAXE];
    bit stab [2][2][MAXE];
    int deb_of [2] = '{8, 3};
    bit rw_of  [2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    sr_cmd_gen #(.DEB_CYCLES(8), .RST_WINS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .S(s0), .R(r0), .conflict(c0)
    );

    sr_cmd_gen #(.DEB_CYCLES(3), .RST_WINS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
        .S(s1), .R(r1), .conflict(c1)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0b expected %0b", tag, edge_n, got, exp);
    endtask

    // Edges before the run started count as reset edges.
    function automatic bit rst_at(input int n);
        if (n < 1) return 1'b1;
        return rr[n];
    endfunction

    // Synchronized request seen at edge n: the input sampled two edges
    // earlier, or 0 if the synchronizer was reset in between.
    function automatic bit seen(input int ch, input int n);
        if (rst_at(n - 1) || rst_at(n - 2)) return 1'b0;
        return (ch == 0) ? xs[n - 2] : xc[n - 2];
    endfunction

    // Stable level after edge n: flips when the last DEB synchronized
    // samples all disagree with the previous stable level.
    function automatic void update_stab(input int n);
        for (int g = 0; g < 2; g++) begin
            for (int ch = 0; ch < 2; ch++) begin
                bit prev;
                bit ok;
                if (rst_at(n)) begin
                    stab[g][ch][n] = 1'b0;
                end else begin
                    prev = stab[g][ch][n - 1];
                    ok   = 1'b1;
                    for (int j = 0; j < deb_of[g]; j++) begin
                        if ((n - j) < 1 || rst_at(n - j) || seen(ch, n - j) == prev) ok = 1'b0;
                    end
                    stab[g][ch][n] = ok ? ~prev : prev;
                end
            end
        end
    endfunction

    // Level presented to the edge detector at edge m.
    function automatic bit lvl_at(input int g, input int ch, input int m);
        if (m < 1) return 1'b0;
        return DEB_ON ? stab[g][ch][m - 1] : seen(ch, m);
    endfunction

    function automatic bit ev_at(input int g, input int ch, input int m);
        bit prev;
        prev = rst_at(m - 1) ? 1'b0 : lvl_at(g, ch, m - 1);
        return lvl_at(g, ch, m) & ~prev;
    endfunction

    task automatic step(input logic s, input logic c, input logic r);
        bit es, ec;
        set_req = s;
        clr_req = c;
        rst     = r;
        @(posedge clk);
        edge_n++;
        xs[edge_n] = s;
        xc[edge_n] = c;
        rr[edge_n] = r;
        update_stab(edge_n);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            es = ev_at(g, 0, edge_n);
            ec = ev_at(g, 1, edge_n);
            if (rst_at(edge_n)) begin
                es = 1'b0;
                ec = 1'b0;
            end
            if (g == 0) begin
                chk("S_cfg0", s0, es & ~ec);
                chk("R_cfg0", r0, ec & (~es | rw_of[0]));
                chk("conflict_cfg0", c0, es & ec);
                chk("SR_excl_cfg0", s0 & r0, 1'b0);
            end else begin
                chk("S_cfg1", s1, es & ~ec);
                chk("R_cfg1", r1, ec & (~es | rw_of[1]));
                chk("conflict_cfg1", c1, es & ec);
                chk("SR_excl_cfg1", s1 & r1, 1'b0);
            end
        end
    endtask

    task automatic hold(input logic s, input logic c, input int n);
        repeat (n) step(s, c, 1'b0);
    endtask

    function automatic int pick_len();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(9, 25));
        return int'($urandom_range(1, 10));
    endfunction

    initial begin
        int   hs;
        int   hc;
        logic ls;
        logic lc;
        rst     = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;

        // Reset state.
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Single held set request.
        hold(1'b0, 1'b0, 20);
        hold(1'b1, 1'b0, 50);
        hold(1'b0, 1'b0, 30);

        // Clear request bouncing every 3 cycles, then held.
        for (int i = 0; i < 10; i++) hold(1'b1 ^ i[0], 1'b0, 0);
        for (int i = 0; i < 10; i++) hold(1'b0, (i % 2) == 0, 3);
        hold(1'b0, 1'b1, 30);
        hold(1'b0, 1'b0, 30);

        // Both requests rise together.
        hold(1'b1, 1'b1, 30);
        hold(1'b0, 1'b0, 30);

        // Set rises two edges before clear.
        hold(1'b1, 1'b0, 2);
        hold(1'b1, 1'b1, 30);
        hold(1'b0, 1'b0, 30);

        // Reset for two cycles in the middle of a set debounce.
        hold(1'b1, 1'b0, 4);
        repeat (2) step(1'b1, 1'b0, 1'b1);
        hold(1'b1, 1'b0, 30);
        hold(1'b0, 1'b0, 30);

        // One-cycle glitches on each request.
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 15);
        hold(1'b0, 1'b1, 1);
        hold(1'b0, 1'b0, 15);

        // Randomized bouncing traffic with occasional aligned edges and resets.
        hs = 0;
        hc = 0;
        ls = 1'b0;
        lc = 1'b0;
        repeat (3000) begin
            if (hs <= 0) begin
                ls = ~ls;
                hs = pick_len();
                if ($urandom_range(0, 4) == 0) begin
                    lc = ls;
                    hc = hs;
                end
            end
            if (hc <= 0) begin
                lc = ~lc;
                hc = pick_len();
            end
            step(ls, lc, $urandom_range(0, 149) == 0);
            hs--;
            hc--;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
